// File: rtl/nexys_io_debounce.sv
// Nexys board input conditioner: per-channel 2-flop synchronizer, counter-based
// debounce, registered edge pulses and sticky W1C pending flags with an OR'd irq.
// DB_CYCLES = 0 bypasses the debounce counters entirely.
module nexys_io_debounce #(
   parameter int unsigned N_CH      = 21,
   parameter int unsigned DB_CYCLES = 50000
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [N_CH-1:0] i_raw,
   input  logic [N_CH-1:0] i_rise_en,
   input  logic [N_CH-1:0] i_fall_en,
   input  logic [N_CH-1:0] i_clr,
   output logic [N_CH-1:0] o_level,
   output logic [N_CH-1:0] o_rise,
   output logic [N_CH-1:0] o_fall,
   output logic [N_CH-1:0] o_pending,
   output logic            o_irq
);

   localparam int unsigned CNT_W = (DB_CYCLES == 0) ? 1 : $clog2(DB_CYCLES + 1);

   logic [N_CH-1:0] r_ff1;
   logic [N_CH-1:0] r_ff2;
   logic [N_CH-1:0] r_level;
   logic [N_CH-1:0] r_rise;
   logic [N_CH-1:0] r_fall;
   logic [N_CH-1:0] r_pending;

   logic [N_CH-1:0] w_level_d;
   logic [N_CH-1:0] w_rise_d;
   logic [N_CH-1:0] w_fall_d;
   logic [N_CH-1:0] w_pending_d;

   // Two-stage synchronizer for the asynchronous board inputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ff1 <= '0;
         r_ff2 <= '0;
      end else begin
         r_ff1 <= i_raw;
         r_ff2 <= r_ff1;
      end
   end

   if (DB_CYCLES == 0) begin : g_bypass
      // No filtering: the level simply follows the synchronized input.
      assign w_level_d = r_ff2;
   end else begin : g_debounce
      localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         logic [CNT_W-1:0] r_cnt;
         logic [CNT_W-1:0] w_cnt_d;
         logic             w_lvl_d;

         // Count consecutive disagreeing samples; accept the new level once
         // the count reaches the window, restart on any agreeing sample.
         always_comb begin
            w_cnt_d = '0;
            w_lvl_d = r_level[i];
            if (r_ff2[i] != r_level[i]) begin
               if (r_cnt == CNT_MAX) begin
                  w_lvl_d = r_ff2[i];
               end else begin
                  w_cnt_d = r_cnt + 1'b1;
               end
            end
         end

         // Per-channel debounce counter state.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               r_cnt <= '0;
            end else begin
               r_cnt <= w_cnt_d;
            end
         end

         assign w_level_d[i] = w_lvl_d;
      end
   end

   // Edge detect on the next-state level so pulses align with the new level;
   // set beats clear when both land on the same edge.
   always_comb begin
      w_rise_d    = w_level_d & ~r_level;
      w_fall_d    = ~w_level_d & r_level;
      w_pending_d = (r_pending & ~i_clr)
                  | (w_rise_d & i_rise_en)
                  | (w_fall_d & i_fall_en);
   end

   // Level, edge pulses and sticky pending flags.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_level   <= '0;
         r_rise    <= '0;
         r_fall    <= '0;
         r_pending <= '0;
      end else begin
         r_level   <= w_level_d;
         r_rise    <= w_rise_d;
         r_fall    <= w_fall_d;
         r_pending <= w_pending_d;
      end
   end

   assign o_level   = r_level;
   assign o_rise    = r_rise;
   assign o_fall    = r_fall;
   assign o_pending = r_pending;
   assign o_irq     = |r_pending;

endmodule
